// File: rtl/dpll_pkg.sv
// Shared sizes and the controller trim-word decoder for the digital PLL core.
`timescale 1ps/1ps
package dpll_pkg;

  localparam int N_STAGES = 13;
  localparam int TRIM_W   = 26;
  localparam int TVAL_W   = 7;
  localparam int CNT_W    = 5;

  // Thermometer decode that alternates between the two trim bits of each stage,
  // so the added delay spreads evenly around the ring: 0, 13, 1, 14, 2, ...
  function automatic logic [TRIM_W-1:0] otrim_decode(input logic [4:0] tint);
    logic [TRIM_W-1:0] t;
    t = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      t[k]            = (2 * k < int'(tint));
      t[k + N_STAGES] = (2 * k + 1 < int'(tint));
    end
    return t;
  endfunction

endpackage

// File: rtl/dpll_ring_osc.sv
// 13-stage trimmable inverting ring. Behavioural delay model; the implementation
// uses hand-placed inverter/trim cells in a kept hierarchy.
`timescale 1ps/1ps
module dpll_ring_osc
  import dpll_pkg::*;
#(
  parameter int STAGE_DLY_PS = 100,
  parameter int TRIM_DLY_PS  = 10
) (
  input  logic              reset,
  input  logic [TRIM_W-1:0] trim,
  output logic [1:0]        clockp
);

  logic [N_STAGES-1:0] stage;

  genvar gi;
  generate
    for (gi = 0; gi < N_STAGES; gi++) begin : gen_stage
      localparam int   PREV    = (gi + N_STAGES - 1) % N_STAGES;
      localparam logic STG_RST = logic'(gi % 2);
      // Stage 0 is pre-charged to its released value so exactly one wavefront
      // enters the ring when reset drops.
      localparam logic RAW_RST = (gi == 0) ? 1'b1 : logic'(gi % 2);

      int   stage_dly;
      logic stage_raw;

      assign stage_dly = STAGE_DLY_PS
                       + TRIM_DLY_PS * (int'(trim[gi]) + int'(trim[gi + N_STAGES]));

      always begin
        if (reset) begin
          stage_raw = RAW_RST;
          wait (!reset);
        end else if (stage_raw != ~stage[PREV]) begin
          #(stage_dly);
          if (!reset) stage_raw = ~stage[PREV];
        end else begin
          @(stage[PREV] or reset);
        end
      end

      assign stage[gi] = reset ? STG_RST : stage_raw;
    end
  endgenerate

  // Inverted stage-6 tap rises seven stage delays after stage 12 rises.
  assign clockp = reset ? 2'b00 : {~stage[6], stage[12]};

endmodule

// File: rtl/digital_pll_core.sv
// Digital PLL: trimmable ring DCO plus a frequency controller that drives the
// trim word so that f(clockp) tracks div * f(osc); dco=1 bypasses to ext_trim.
`timescale 1ps/1ps
module digital_pll_core
  import dpll_pkg::*;
#(
  parameter int STAGE_DLY_PS = 100,
  parameter int TRIM_DLY_PS  = 10
) (
`ifdef USE_POWER_PINS
  inout  wire               VPWR,
  inout  wire               VGND,
`endif
  input  logic              osc,
  input  logic              resetb,
  input  logic              enable,
  input  logic              dco,
  input  logic [4:0]        div,
  input  logic [TRIM_W-1:0] ext_trim,
  output logic [1:0]        clockp
);

  logic              iresetb;
  logic              ireset;
  logic [TRIM_W-1:0] otrim;
  logic [TRIM_W-1:0] trim;

  logic [2:0]        s_reg, s_next;
  logic [CNT_W-1:0]  count0_reg, count0_next;
  logic [CNT_W-1:0]  count1_reg, count1_next;
  logic [TVAL_W-1:0] tval_reg, tval_next;
  logic [CNT_W:0]    sum;
  logic              osc_edge;

  assign iresetb = resetb & enable;
  assign ireset  = ~iresetb;

  assign otrim = otrim_decode(tval_reg[TVAL_W-1:2]);
  assign trim  = dco ? ext_trim : otrim;

  dpll_ring_osc #(
    .STAGE_DLY_PS(STAGE_DLY_PS),
    .TRIM_DLY_PS (TRIM_DLY_PS)
  ) u_ring (
    .reset (ireset),
    .trim  (trim),
    .clockp(clockp)
  );

  always_comb begin
    s_next      = {s_reg[1:0], osc};
    count0_next = count0_reg;
    count1_next = count1_reg;
    tval_next   = tval_reg;
    osc_edge    = s_reg[2] ^ s_reg[1];
    sum         = {1'b0, count0_reg} + {1'b0, count1_reg};

    // sum is the DCO cycle count over the last full osc period (two halves).
    if (osc_edge) begin
      count1_next = count0_reg;
      count0_next = CNT_W'(1);
      if (sum > {1'b0, div}) begin
        if (tval_reg != '1) tval_next = tval_reg + TVAL_W'(1);
      end else if (sum < {1'b0, div}) begin
        if (tval_reg != '0) tval_next = tval_reg - TVAL_W'(1);
      end
    end else if (count0_reg != '1) begin
      count0_next = count0_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clockp[0] or negedge iresetb) begin
    if (!iresetb) begin
      s_reg      <= '0;
      count0_reg <= '0;
      count1_reg <= '0;
      tval_reg   <= '0;
    end else begin
      s_reg      <= s_next;
      count0_reg <= count0_next;
      count1_reg <= count1_next;
      tval_reg   <= tval_next;
    end
  end

endmodule

// File: tb/tb_digital_pll_core.sv
// Directed bench for digital_pll_core: open-loop period/phase table, reset,
// closed-loop lock, retarget, saturation and mid-run disable.
`timescale 1ps/1ps
module tb_digital_pll_core;

  logic        osc = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b1;
  logic        dco = 1'b1;
  logic [4:0]  div = 5'd8;
  logic [25:0] ext_trim = '0;
  logic [1:0]  clockp;

  int n_checks = 0;
  int n_pass   = 0;

  longint n0 = 0;
  longint t0_last = 0;
  longint t0_prev = 0;
  longint t1_last = 0;

  typedef struct {
    logic [25:0] trim;
    longint      per;
    longint      lag;
  } vec_t;

  vec_t vecs [8];

  digital_pll_core dut (
    .osc     (osc),
    .resetb  (resetb),
    .enable  (enable),
    .dco     (dco),
    .div     (div),
    .ext_trim(ext_trim),
    .clockp  (clockp)
  );

  // 24 ns reference
  always #12000 osc = ~osc;

  always @(posedge clockp[0]) begin
    t0_prev <= t0_last;
    t0_last <= longint'($time);
    n0      <= n0 + 1;
  end

  always @(posedge clockp[1]) t1_last <= longint'($time);

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act >= lo && act <= hi) begin
      n_pass++;
      $display("ok   %s: got %0d (want %0d..%0d)", name, act, lo, hi);
    end else begin
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic edges_per_osc(output longint e);
    longint c;
    @(posedge osc);
    #1;
    c = n0;
    @(posedge osc);
    #1;
    e = n0 - c;
  endtask

  task automatic check_edges(input string name, input longint lo, input longint hi);
    longint e;
    for (int k = 0; k < 3; k++) begin
      edges_per_osc(e);
      check($sformatf("%s[%0d]", name, k), e, lo, hi);
    end
  endtask

  task automatic wait_osc(input int n);
    repeat (n) @(posedge osc);
    #1;
  endtask

  initial begin
    longint per, lag, c, tv1, tv2, tv_hi;

    // Period = 2 * sum(stage delays); lag = sum of delays of stages 0..6.
    vecs[0] = '{26'h0000000, 2600, 700};
    vecs[1] = '{26'h3FFFFFF, 3120, 840};
    vecs[2] = '{26'h0000001, 2620, 710};
    vecs[3] = '{26'h0002000, 2620, 710};
    vecs[4] = '{26'h0001000, 2620, 700};
    vecs[5] = '{26'h0002001, 2640, 720};
    vecs[6] = '{26'h000007F, 2740, 770};
    vecs[7] = '{26'h0001F80, 2720, 700};

    // Reset held: ring silent
    #1000;
    check("rst_clockp_early", longint'(clockp), 0, 0);
    check("rst_tval", longint'(dut.tval_reg), 0, 0);
    #999000;
    check("rst_clockp_late", longint'(clockp), 0, 0);
    check("rst_no_toggles", n0, 0, 0);
    resetb = 1'b1;
    #10000;
    check("release_toggles", n0, 2, 10);

    // Open-loop trim table
    for (int i = 0; i < 8; i++) begin
      ext_trim = vecs[i].trim;
      #20001;
      per = t0_last - t0_prev;
      lag = t1_last - t0_last;
      if (lag < 0) lag += per;
      check($sformatf("ol_period[%0d]", i), per, vecs[i].per, vecs[i].per);
      check($sformatf("ol_quad_lag[%0d]", i), lag, vecs[i].lag, vecs[i].lag);
    end

    // Closed loop at div=8
    dco = 1'b0;
    div = 5'd8;
    wait_osc(200);
    check_edges("lock8_edges", 7, 9);
    tv1 = longint'(dut.tval_reg);
    wait_osc(20);
    tv2 = longint'(dut.tval_reg);
    check("lock8_tval_nonzero", tv2, 1, 127);
    check("lock8_tval_drift", (tv2 > tv1) ? tv2 - tv1 : tv1 - tv2, 0, 8);

    // Retarget above the fastest achievable rate: trim walks down to 0
    div = 5'd10;
    wait_osc(20);
    check("retarget_tval_down", longint'(dut.tval_reg), 0, tv2 - 1);
    wait_osc(150);
    check("retarget_tval_floor", longint'(dut.tval_reg), 0, 0);
    check_edges("retarget_edges", 9, 10);

    // Target below the slowest achievable rate: trim saturates high
    div = 5'd4;
    wait_osc(100);
    tv_hi = longint'(dut.tval_reg);
    check("slow_tval_ceiling", tv_hi, 127, 127);
    check_edges("slow_edges", 7, 8);

    // Mid-run disable and relock
    div = 5'd8;
    wait_osc(100);
    enable = 1'b0;
    #1000;
    c = n0;
    check("dis_clockp_early", longint'(clockp), 0, 0);
    check("dis_tval", longint'(dut.tval_reg), 0, 0);
    #49000;
    check("dis_clockp_late", longint'(clockp), 0, 0);
    check("dis_no_toggles", n0 - c, 0, 0);
    enable = 1'b1;
    wait_osc(200);
    check_edges("relock8_edges", 7, 9);
    check("relock8_tval_nonzero", longint'(dut.tval_reg), 1, 127);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
